// File: rtl/ctrl_pipe.sv
// Control-signal pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// taken-branch flush and EX operand forwarding selects.
module ctrl_pipe #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CTRL_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [CTRL_WIDTH-1:0]     id_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      ex_branch_taken,
    output logic                      stall,
    output logic                      flush_ifid,
    output logic                      ex_valid,
    output logic [CTRL_WIDTH-1:0]     ex_ctrl,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      mem_MemRead,
    output logic                      mem_MemWrite,
    output logic                      mem_MemtoReg,
    output logic                      mem_RegWrite,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output logic                      wb_MemtoReg,
    output logic                      wb_RegWrite,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [1:0]                fwd_a,
    output logic [1:0]                fwd_b
);

    // Bit positions within the control bundle (MSB first: ALUSrc..ALUOp).
    localparam int unsigned B_MEMTOREG = 6;
    localparam int unsigned B_REGWRITE = 5;
    localparam int unsigned B_MEMREAD  = 4;
    localparam int unsigned B_MEMWRITE = 3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // ID/EX state
    logic                      ex_valid_q, ex_valid_d;
    logic [CTRL_WIDTH-1:0]     ex_ctrl_q,  ex_ctrl_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_q,   ex_rs1_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2_q,   ex_rs2_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q,    ex_rd_d;
    // EX/MEM state
    logic                      mem_memread_q,  mem_memwrite_q;
    logic                      mem_memtoreg_q, mem_regwrite_q;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q;
    // MEM/WB state
    logic                      wb_memtoreg_q, wb_regwrite_q;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q;

    logic lu;

    // Load-use: both rs fields compared regardless of instruction format.
    always_comb begin
        lu = id_valid && ex_ctrl_q[B_MEMREAD] && (ex_rd_q != '0) &&
             ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    end

    assign stall      = lu && !ex_branch_taken;
    assign flush_ifid = ex_branch_taken;

    // ID/EX next state: any bubble condition yields all-zero contents.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        ex_rd_d    = '0;
        if (!ex_branch_taken && !lu && id_valid) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = id_ctrl;
            ex_rs1_d   = id_rs1;
            ex_rs2_d   = id_rs2;
            ex_rd_d    = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
            wb_memtoreg_q  <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_rd_q        <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            // Later stages always advance; a flush only affects ID/EX.
            mem_memread_q  <= ex_ctrl_q[B_MEMREAD];
            mem_memwrite_q <= ex_ctrl_q[B_MEMWRITE];
            mem_memtoreg_q <= ex_ctrl_q[B_MEMTOREG];
            mem_regwrite_q <= ex_ctrl_q[B_REGWRITE];
            mem_rd_q       <= ex_rd_q;
            wb_memtoreg_q  <= mem_memtoreg_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_rd_q        <= mem_rd_q;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB; x0 never forwards.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) begin
            fwd_a = FWD_MEM;
        end else if (wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) begin
            fwd_a = FWD_WB;
        end
        if (mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) begin
            fwd_b = FWD_MEM;
        end else if (wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) begin
            fwd_b = FWD_WB;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign mem_MemRead  = mem_memread_q;
    assign mem_MemWrite = mem_memwrite_q;
    assign mem_MemtoReg = mem_memtoreg_q;
    assign mem_RegWrite = mem_regwrite_q;
    assign mem_rd       = mem_rd_q;
    assign wb_MemtoReg  = wb_memtoreg_q;
    assign wb_RegWrite  = wb_regwrite_q;
    assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: forwarding, load-use, branch flush, reset, x0, invalid ID.
module tb_ctrl_pipe;

    localparam int unsigned RA = 5;
    localparam int unsigned CW = 8;
    localparam logic [7:0] C_ADD = 8'b0010_0010;
    localparam logic [7:0] C_LW  = 8'b1111_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [CW-1:0] id_ctrl;
    logic [RA-1:0] id_rs1, id_rs2, id_rd;
    logic          ex_branch_taken;
    logic          stall, flush_ifid, ex_valid;
    logic [CW-1:0] ex_ctrl;
    logic [RA-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite;
    logic [RA-1:0] mem_rd;
    logic          wb_MemtoReg, wb_RegWrite;
    logic [RA-1:0] wb_rd;
    logic [1:0]    fwd_a, fwd_b;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_ADDR_WIDTH(RA), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush_ifid(flush_ifid),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_MemtoReg(mem_MemtoReg), .mem_RegWrite(mem_RegWrite),
        .mem_rd(mem_rd),
        .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [7:0] c,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        id_valid = v;
        id_ctrl  = c;
        id_rs1   = r1;
        id_rs2   = r2;
        id_rd    = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_ex_ctrl",  8'(ex_ctrl), 8'h00);
        check("rst_ex_valid", 8'(ex_valid), 8'h00);
        check("rst_mem_rw",   8'(mem_RegWrite), 8'h00);
        check("rst_wb_rw",    8'(wb_RegWrite), 8'h00);
        check("rst_stall",    8'(stall), 8'h00);
        check("rst_fwd",      8'({fwd_a, fwd_b}), 8'h00);

        // Forwarding: add x3,x1,x2 ; sub x4,x3,x3 ; or x5,x3,x0
        set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
        step();
        check("add_ex_ctrl",  8'(ex_ctrl), C_ADD);
        check("add_ex_rd",    8'(ex_rd), 8'd3);
        check("add_ex_valid", 8'(ex_valid), 8'h01);
        set_id(1'b1, C_ADD, 5'd3, 5'd3, 5'd4);
        step();
        check("sub_fwd_a", 8'(fwd_a), 8'b10);
        check("sub_fwd_b", 8'(fwd_b), 8'b10);
        check("add_mem_rw", 8'(mem_RegWrite), 8'h01);
        set_id(1'b1, C_ADD, 5'd3, 5'd0, 5'd5);
        step();
        check("or_fwd_a",  8'(fwd_a), 8'b01);
        check("or_fwd_b",  8'(fwd_b), 8'b00);
        check("sub_mem_rd", 8'(mem_rd), 8'd4);
        check("add_wb_rd",  8'(wb_rd), 8'd3);
        check("add_wb_rw",  8'(wb_RegWrite), 8'h01);

        // Reset mid-stream with the pipe full
        rst = 1'b1;
        set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
        step();
        rst = 1'b0;
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        check("mid_rst_ex_ctrl", 8'(ex_ctrl), 8'h00);
        check("mid_rst_mem_rw",  8'(mem_RegWrite), 8'h00);
        check("mid_rst_wb_rw",   8'(wb_RegWrite), 8'h00);
        check("mid_rst_stall",   8'(stall), 8'h00);
        check("mid_rst_fwd",     8'({fwd_a, fwd_b}), 8'h00);

        // Load-use: lw x5,0(x1) ; add x6,x5,x1
        set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd5);
        step();
        set_id(1'b1, C_ADD, 5'd5, 5'd1, 5'd6);
        check("lu_stall", 8'(stall), 8'h01);
        check("lu_flush", 8'(flush_ifid), 8'h00);
        step();
        check("lu_bubble_ctrl",  8'(ex_ctrl), 8'h00);
        check("lu_bubble_valid", 8'(ex_valid), 8'h00);
        check("lu_stall_once",   8'(stall), 8'h00);
        check("lu_mem_memread",  8'(mem_MemRead), 8'h01);
        check("lu_mem_rd",       8'(mem_rd), 8'd5);
        step();
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        check("lu_add_ex_ctrl", 8'(ex_ctrl), C_ADD);
        check("lu_fwd_a",       8'(fwd_a), 8'b01);
        check("lu_fwd_b",       8'(fwd_b), 8'b00);
        check("lu_wb_memtoreg", 8'(wb_MemtoReg), 8'h01);
        step();
        step();
        step();

        // Branch over a load-use hazard
        set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd5);
        step();
        ex_branch_taken = 1'b1;
        set_id(1'b1, C_ADD, 5'd5, 5'd1, 5'd6);
        check("br_stall", 8'(stall), 8'h00);
        check("br_flush", 8'(flush_ifid), 8'h01);
        step();
        ex_branch_taken = 1'b0;
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        check("br_ex_valid",     8'(ex_valid), 8'h00);
        check("br_ex_ctrl",      8'(ex_ctrl), 8'h00);
        check("br_lw_completes", 8'(mem_MemRead), 8'h01);

        // Two consecutive taken branches: one bubble each, then normal flow
        ex_branch_taken = 1'b1;
        set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd7);
        step();
        check("br2_first_bubble", 8'(ex_valid), 8'h00);
        step();
        check("br2_second_bubble", 8'(ex_valid), 8'h00);
        ex_branch_taken = 1'b0;
        #1;
        check("br2_flush_drop", 8'(flush_ifid), 8'h00);
        step();
        check("br2_resume_valid", 8'(ex_valid), 8'h01);
        check("br2_resume_rd",    8'(ex_rd), 8'd7);
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        step();
        step();
        step();

        // x0 writes: lw x0 ; add x1,x0,x0
        set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd0);
        step();
        set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd1);
        check("x0_no_stall", 8'(stall), 8'h00);
        step();
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        check("x0_ex_valid", 8'(ex_valid), 8'h01);
        check("x0_fwd",      8'({fwd_a, fwd_b}), 8'h00);
        step();
        step();
        step();

        // Invalid ID with a fully-set control bundle
        set_id(1'b0, 8'hFF, 5'd3, 5'd4, 5'd5);
        step();
        check("inv_ex_ctrl", 8'(ex_ctrl), 8'h00);
        step();
        check("inv_mem_ctrl",
              8'({mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite}), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Control-signal pipeline and hazard unit that sits downstream of the ID-stage control decoder in the five-stage RISC-V core. It latches the decoded control bundle into ID/EX, carries the relevant fields through EX/MEM and MEM/WB, and issues the signals that drive the rest of the core:
- load-use stalls;
- taken-branch flushes;
- EX operand forwarding selects.

## Interface
- REG_ADDR_WIDTH, 5, register-specifier width.
- CTRL_WIDTH, 8, control bundle width. Packing is {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}, MSB first.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  CTRL_WIDTH  decoder bundle for the ID instruction.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  register specifiers of the ID instruction.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- stall  out  1  combinational; hold PC and IF/ID.
- flush_ifid  out  1  combinational; zero IF/ID.
- ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd  out  1/CTRL_WIDTH/RA/RA/RA  ID/EX register.
- mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite  out  1 each  EX/MEM control.
- mem_rd  out  RA  EX/MEM destination register.
- wb_MemtoReg, wb_RegWrite  out  1 each  MEM/WB control.
- wb_rd  out  RA  MEM/WB destination register.
- fwd_a, fwd_b  out  2  combinational EX operand selects. 00 = register file, 10 = EX/MEM, 01 = MEM/WB.

## Operation
- **Bubble** means ex_valid=0 and ex_ctrl, ex_rs1, ex_rs2, ex_rd all 0.
- **Load-use hazard (lu):** id_valid & ex_MemRead & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Both rs fields are always compared (conservative, format-independent).
- **Outputs:**
  - stall = lu & ~ex_branch_taken.
  - flush_ifid = ex_branch_taken.
- **ID/EX update, priority order:**
  1. rst → bubble.
  2. ex_branch_taken → bubble.
  3. lu → bubble.
  4. id_valid=0 → bubble.
  5. Otherwise load id_ctrl/rs1/rs2/rd with ex_valid=1.
- **EX/MEM:** always advances from ID/EX, independent of stall or flush.
  - mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite ← corresponding ex_ctrl bits; mem_rd ← ex_rd.
  - A branch in EX still completes into MEM; its own RegWrite bit governs.
- **MEM/WB:** always advances from EX/MEM (wb_* ← mem_*).
- **Forwarding (fwd_a shown; fwd_b identical using ex_rs2):**
  - 10 if mem_RegWrite & mem_rd≠0 & mem_rd==ex_rs1;
  - else 01 if wb_RegWrite & wb_rd≠0 & wb_rd==ex_rs1;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- x0 never produces a stall or a non-zero forward select.

## Timing
- Reset: every registered output is 0 on the edge where rst=1. Combinational outputs are then also 0.
- rst asserted mid-operation clears all three stages in that same edge. In-flight instructions are dropped, never completed.
- Latency: id_ctrl appears on ex_ctrl 1 cycle after capture, on mem_* after 2 cycles, on wb_* after 3 cycles.
- stall holds for exactly one cycle per load-use pair. On the next edge the load moves to MEM and ex_MemRead drops (bubble in EX).
- stall and flush_ifid are never both 1.
- Simultaneous branch and load-use: the flush wins, stall=0, and the stalled ID instruction is discarded.
- Consecutive taken branches each produce one bubble, with no lost or extra cycles.

## Test plan
- **Reset mid-stream:** fill the pipe with add x3,x1,x2, then assert rst for 1 cycle.
  - Required: next cycle ex_ctrl=0, mem_RegWrite=0, wb_RegWrite=0, stall=0, fwd_a=fwd_b=00.
- **Forwarding:** add x3,x1,x2 (ctrl 8'b00100010) followed by sub x4,x3,x3, then or x5,x3,x0.
  - Required: sub in EX → fwd_a=fwd_b=10; or in EX → fwd_a=01, fwd_b=00.
- **Load-use:** lw x5 (ctrl 8'b11110000) then add x6,x5,x1.
  - Required: stall=1 for exactly 1 cycle and ex_ctrl=0 in the following cycle.
  - Required: add then enters EX with fwd_a=01, fwd_b=00.
- **Branch over hazard:** lw x5 in EX, dependent instruction in ID, ex_branch_taken=1 in the same cycle.
  - Required: stall=0, flush_ifid=1, next-cycle ex_valid=0.
- **x0 writes:** lw x0 then add x1,x0,x0.
  - Required: no stall; add in EX has fwd_a=fwd_b=00.
- **Invalid ID:** id_valid=0 with id_ctrl=8'hFF.
  - Required: ex_ctrl=0 next cycle, and mem_* stay 0 the cycle after.
